bcd_saida_ctrl: RTL and testbench
=================================

# bcd_saida_ctrl

Sequential controller for the output path's binary-to-BCD conversion. It accepts output write requests from the processor core, converts one 32-bit value per request using the shift/add-3 algorithm one bit per clock, and holds the resulting three display digits stable between updates. A one-deep pending register absorbs a request that arrives while a conversion is running.

## Interface
- `LARGURA`, default 32: width of the binary operand; also the number of shift iterations.
- `clock`  in  1: system clock; all state changes on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `escrever`  in  1: write strobe from the core.
- `controlesaida`  in  2: output selector; a request is `escrever==1 && controlesaida==2'b01` in the same cycle.
- `binario`  in  LARGURA: value to convert, sampled in the request cycle.
- `unidade`, `dezena`, `centena`  out  4 each: registered display digits.
- `estouro`  out  1: registered; 1 when the displayed value came from an operand ≥ 1000.
- `ocupado`  out  1: 1 while a conversion is running (states SHIFT and DONE).
- `pronto`  out  1: one-cycle pulse when new digits appear on the outputs.

## Operation
- States:
  - IDLE: no conversion running.
  - SHIFT: one iteration per clock; `cnt` runs 0..LARGURA-1.
  - DONE: outputs are committed.
- IDLE → SHIFT on a request, or when the pending register is valid; a pending value takes the slot first.
- Entering SHIFT loads:
  - `sh` ← operand;
  - `bcd` (12 bits) ← 0;
  - `cnt` ← 0;
  - `ovf` ← (operand ≥ 1000, unsigned).
- SHIFT iteration, in this order:
  - each BCD nibble ≥ 5 gets +3;
  - `{bcd, sh}` shifts left by 1; the MSB of `sh` enters bit 0 of `bcd`;
  - bits shifted out of the top of `bcd` are discarded;
  - `cnt`++.
- SHIFT → DONE on the edge where `cnt == LARGURA-1`, after LARGURA iterations in total.
- DONE (one cycle): outputs update as follows.
  - If `ovf==0`: `centena`/`dezena`/`unidade` ← `bcd[11:8]`/`[7:4]`/`[3:0]`, `estouro` ← 0.
  - If `ovf==1`: digits ← 9/9/9, `estouro` ← 1.
- Leaving DONE: `pronto` pulses high for the next cycle. Next state is SHIFT if pending is valid (pending consumed), else IDLE.
- Pending register (`pend_val`, `pend_v`):
  - A request while `ocupado==1` stores `binario` and sets `pend_v`.
  - A further request while `pend_v==1` overwrites the value (latest wins); there is never more than one pending entry.
  - A request in IDLE goes straight to SHIFT and is never stored.
- Requests with `controlesaida != 2'b01` are ignored entirely.
- Reset (any time, including mid-conversion):
  - state ← IDLE; `cnt`, `sh`, `bcd`, `pend_v`, `ovf` ← 0;
  - all digits ← 0, `estouro` ← 0, `pronto` ← 0;
  - an in-flight conversion is discarded and no `pronto` follows.

## Timing
- Request sampled at edge k (IDLE) → SHIFT from k. Iterations run at edges k+1..k+LARGURA. DONE is the state after edge k+LARGURA.
- Digits change at edge k+LARGURA+1, i.e. k+33 with the default width. `pronto` is high during the cycle following that edge.
- `ocupado` goes high after edge k and goes low after the DONE edge when nothing is pending.
- Back-to-back: with pending valid at DONE, the next SHIFT load happens on the DONE edge. Throughput is one conversion per LARGURA+1 cycles, and `ocupado` stays high continuously.
- A request in the same cycle as the DONE edge:
  - if `pend_v==0`, it is stored to pending and started at the next IDLE decision (one cycle later);
  - if `pend_v==1`, it overwrites pending while the old pending value is being consumed on that edge. The new value stays pending with `pend_v` held at 1.
- Outputs hold their previous values throughout SHIFT; there are no glitches on the digits.

## Test plan
- Reset low, then release; one request with `binario=123`:
  - 2/3 → `centena=1`, `dezena=2`, `unidade=3`, `estouro=0`;
  - 1/3 → digits and `pronto` change exactly 33 cycles after the request edge;
  - 3/3 → `pronto` is high for exactly 1 cycle.
- Sequential requests `0`, `999`, `1000`, `32'hFFFFFFFF`:
  - `0` → 0/0/0, `estouro=0`;
  - `999` → 9/9/9, `estouro=0`;
  - `1000` → 9/9/9, `estouro=1`;
  - `32'hFFFFFFFF` → 9/9/9, `estouro=1`.
- Request 45, then requests 67 and 89 during its SHIFT:
  - outputs show 045, then 089; 67 is dropped;
  - exactly two `pronto` pulses;
  - `ocupado` high continuously from the first request until 33 cycles after the 089 conversion starts.
- Request with `controlesaida=2'b10` or `escrever=0`, `binario=500` → no state change, `ocupado` stays 0, outputs unchanged.
- Reset asserted at iteration 15 of a conversion of 321:
  - digits and `estouro` go to 0 immediately (asynchronously);
  - no `pronto` pulse;
  - a subsequent request for 7 produces 0/0/7.
- Request arriving in the same cycle as the DONE edge of a prior conversion (`pend_v==0`) → stored, conversion starts one cycle later, and its result appears 34 cycles after that request edge.

Source files
------------

// File: rtl/bcd_saida_ctrl.sv
// bcd_saida_ctrl: sequential shift/add-3 binary-to-BCD converter for the output path,
// holding three display digits with a one-deep pending request slot.
module bcd_saida_ctrl #(
  parameter int LARGURA = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               escrever,
  input  logic [1:0]         controlesaida,
  input  logic [LARGURA-1:0] binario,
  output logic [3:0]         unidade,
  output logic [3:0]         dezena,
  output logic [3:0]         centena,
  output logic               estouro,
  output logic               ocupado,
  output logic               pronto
);
  localparam int CW = (LARGURA > 1) ? $clog2(LARGURA) : 1;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t             r_state, w_next;
  logic [LARGURA-1:0] r_sh, r_pend_val, w_op;
  logic [11:0]        r_bcd, w_adj;
  logic [CW-1:0]      r_cnt;
  logic               r_pend_v, r_ovf, w_req, w_start, w_consume, w_load_pend;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  assign w_req       = escrever && controlesaida == 2'b01;
  assign ocupado     = r_state != IDLE;
  assign w_adj       = {add3(r_bcd[11:8]), add3(r_bcd[7:4]), add3(r_bcd[3:0])};
  assign w_consume   = w_start && r_pend_v;
  assign w_load_pend = w_req && (ocupado || r_pend_v);

  // A pending value always wins the slot over a fresh request
  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_op    = r_pend_val;
    case (r_state)
      IDLE: begin
        w_start = r_pend_v || w_req;
        w_op    = r_pend_v ? r_pend_val : binario;
        w_next  = w_start ? SHIFT : IDLE;
      end
      SHIFT: w_next = (r_cnt == CW'(LARGURA - 1)) ? DONE : SHIFT;
      DONE: begin
        w_start = r_pend_v;
        w_next  = r_pend_v ? SHIFT : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset)
    if (!reset) r_state <= IDLE;
    else r_state <= w_next;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sh       <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      r_pend_v   <= 1'b0;
      r_pend_val <= '0;
      pronto     <= 1'b0;
      estouro    <= 1'b0;
      {centena, dezena, unidade} <= '0;
    end else begin
      if (w_start) begin
        r_sh  <= w_op;
        r_bcd <= '0;
        r_cnt <= '0;
        r_ovf <= w_op >= LARGURA'(1000);
      end else if (r_state == SHIFT) begin
        r_sh  <= r_sh << 1;
        r_bcd <= 12'({w_adj, r_sh[LARGURA-1]});
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_load_pend) r_pend_val <= binario;
      r_pend_v <= w_load_pend || (r_pend_v && !w_consume);
      pronto   <= r_state == DONE;
      if (r_state == DONE) begin
        {centena, dezena, unidade} <= r_ovf ? 12'h999 : r_bcd;
        estouro <= r_ovf;
      end
    end
  end
endmodule

// File: tb/tb_bcd_saida_ctrl.sv
// tb_bcd_saida_ctrl: randomized scoreboard bench; expected digits come from decimal
// arithmetic on the operand, and a monitor pops them whenever pronto is seen.
module tb_bcd_saida_ctrl;
  logic        clock = 1'b0, reset = 1'b1, escrever = 1'b0;
  logic [1:0]  controlesaida = 2'b00;
  logic [31:0] binario = '0;
  logic [3:0]  unidade, dezena, centena;
  logic        estouro, ocupado, pronto;
  int checks = 0, failures = 0, cyc = 0, drops = 0, k = 0, t = 0;
  logic [31:0] v;
  typedef struct { logic [12:0] dig; int at; } exp_t;
  exp_t exp_q[$];
  exp_t e;
  logic [12:0] last = '0;
  logic prev_pronto = 1'b0;

  bcd_saida_ctrl #(.LARGURA(32)) dut (
    .clock(clock), .reset(reset), .escrever(escrever), .controlesaida(controlesaida),
    .binario(binario), .unidade(unidade), .dezena(dezena), .centena(centena),
    .estouro(estouro), .ocupado(ocupado), .pronto(pronto)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [12:0] model(input logic [31:0] x);
    int unsigned d;
    d = (x >= 32'd1000) ? 32'd999 : x;
    return {4'(d / 100), 4'((d / 10) % 10), 4'(d % 10), x >= 32'd1000};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, req);
    end
  endtask

  task automatic req(input logic [31:0] x);
    escrever = 1'b1; controlesaida = 2'b01; binario = x;
    @(negedge clock); #1;
    escrever = 1'b0; controlesaida = 2'b00; binario = $urandom;
  endtask

  task automatic push(input logic [31:0] x, input int at);
    exp_q.push_back('{model(x), at});
  endtask

  task automatic at_edge(input int n);
    while (cyc + 1 < n) begin @(negedge clock); #1; end
  endtask

  task automatic send(input logic [31:0] x);
    push(x, cyc + 1 + 33);
    req(x);
  endtask

  task automatic wait_idle();
    t = 0;
    while ((ocupado || exp_q.size() != 0) && t < 200) begin @(negedge clock); #1; t++; end
    check("idle_timeout", t < 200, 1);
    @(negedge clock); #1;
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      last = '0;
      prev_pronto = 1'b0;
    end else begin
      if (pronto) begin
        check("pronto_width", prev_pronto, 0);
        check("expected_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("digits", {centena, dezena, unidade, estouro}, e.dig);
          check("latency", cyc, e.at);
        end
        last = {centena, dezena, unidade, estouro};
      end else check("hold", {centena, dezena, unidade, estouro}, last);
      prev_pronto = pronto;
    end
  end

  initial begin
    #1 reset = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    check("rst_digits", {centena, dezena, unidade, estouro}, 0);
    check("rst_ocupado", ocupado, 0);
    check("rst_pronto", pronto, 0);
    reset = 1'b1;
    @(negedge clock); #1;
    send(123);
    wait_idle();
    foreach (exp_q[i]) check("queue_drained", exp_q.size(), 0);
    send(0);  wait_idle();
    send(999); wait_idle();
    send(1000); wait_idle();
    send(32'hFFFFFFFF); wait_idle();
    k = cyc + 1;
    fork
      begin
        push(45, k + 33); req(45);
        at_edge(k + 10); req(67);
        at_edge(k + 20); push(89, k + 66); req(89);
      end
      begin
        drops = 0;
        @(negedge clock); #1;
        while (cyc < k + 66) begin
          if (!ocupado) drops++;
          @(negedge clock); #1;
        end
        check("ocupado_drops", drops, 0);
        check("ocupado_end", ocupado, 0);
      end
    join
    wait_idle();
    escrever = 1'b1; controlesaida = 2'b10; binario = 500;
    @(negedge clock); #1;
    check("ignored_ctl", ocupado, 0);
    escrever = 1'b0; controlesaida = 2'b01;
    @(negedge clock); #1;
    check("ignored_wr", ocupado, 0);
    controlesaida = 2'b00;
    repeat (3) begin @(negedge clock); #1; check("ignored_idle", ocupado, 0); end
    k = cyc + 1;
    push(321, k + 33); req(321);
    at_edge(k + 16);
    reset = 1'b0;
    #1;
    check("async_rst_digits", {centena, dezena, unidade, estouro}, 0);
    exp_q.delete();
    @(negedge clock); #1;
    check("rst_mid_ocupado", ocupado, 0);
    check("rst_mid_pronto", pronto, 0);
    reset = 1'b1;
    repeat (40) begin @(negedge clock); #1; end
    send(7); wait_idle();
    k = cyc + 1;
    push(250, k + 33); req(250);
    at_edge(k + 33);
    push(618, k + 67); req(618);
    wait_idle();
    repeat (15) begin
      v = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 1100);
      send(v);
      wait_idle();
    end
    repeat (4) begin
      k = cyc + 1;
      v = $urandom_range(0, 1100);
      push(v, k + 33); req(v);
      t = k + 2 + $urandom_range(0, 8);
      for (int n = $urandom_range(1, 3); n > 0; n--) begin
        at_edge(t);
        v = ($urandom_range(0, 1) == 0) ? $urandom : $urandom_range(0, 1100);
        if (n == 1) push(v, k + 66);
        req(v);
        t = t + $urandom_range(2, 8);
      end
      wait_idle();
    end
    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
